// File: rtl/lcd_i2c_rx.sv
// I2C write-only responder emulating a PCF8574 LCD backpack; rebuilds HD44780 bytes from E strobes.
// Optional LCD_RX_DDRAM_EN adds a 32-entry shadow DDRAM with cursor tracking.
module lcd_i2c_rx #(
    parameter logic [6:0] ADDR = 7'h27
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        sda,
    input  logic       sclk,
    output logic [7:0] port,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       mode4,
    output logic       busy,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_DATA, S_ACK_D, S_IGNORE
    } state_t;

    state_t        state, state_n;
    logic [1:0]    scl_sync, sda_sync;
    logic          scl_prev, sda_prev;
    logic          scl_q, sda_q, scl_rise, scl_fall, start, stop;
    logic [CW-1:0] bit_cnt;
    logic [BW-1:0] shift, nb;
    logic          sda_low, ack_n, strobe;
    logic          phase, hi_rs;
    logic [3:0]    hi;

    // Two-flop synchronizers plus edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], sclk};
            sda_sync <= {sda_sync[0], sda};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl_q    = scl_sync[1];
    assign sda_q    = sda_sync[1];
    assign scl_rise = scl_q & ~scl_prev;
    assign scl_fall = ~scl_q & scl_prev;
    assign start    = scl_q & scl_prev & sda_prev & ~sda_q;
    assign stop     = scl_q & scl_prev & ~sda_prev & sda_q;
    assign nb       = {shift[6:0], sda_q};

    always_comb begin
        state_n = state;
        ack_n   = 1'b0;
        case (state)
            S_ADDR: if (scl_fall && bit_cnt == CW'(8))
                        state_n = (shift[7:1] == ADDR && !shift[0]) ? S_ACK_A : S_IGNORE;
            S_ACK_A, S_ACK_D: if (scl_fall && bit_cnt == CW'(9)) state_n = S_DATA;
            S_DATA: if (scl_fall && bit_cnt == CW'(8)) state_n = S_ACK_D;
            default: ;
        endcase
        if (start)     state_n = S_ADDR;
        else if (stop) state_n = S_IDLE;
        ack_n = (state_n == S_ACK_A) || (state_n == S_ACK_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sda_low <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
            port    <= 8'hFF;
            strobe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            sda_low <= ack_n;
            strobe  <= 1'b0;
            if (start || (state_n == S_DATA && state != S_DATA))
                bit_cnt <= '0;
            else if (scl_rise && state != S_IDLE && state != S_IGNORE)
                bit_cnt <= bit_cnt + CW'(1);
            if (scl_rise && (state == S_ADDR || state == S_DATA))
                shift <= nb;
            // Eighth data bit: latch the expander port and flag a falling E with RW=0
            if (scl_rise && state == S_DATA && bit_cnt == CW'(7)) begin
                port   <= nb;
                strobe <= port[2] & ~nb[2] & ~nb[1];
            end
            if (stop)                  busy <= 1'b0;
            else if (state == S_ACK_A) busy <= 1'b1;
        end
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

    // HD44780 byte reassembly from E strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid <= 1'b0;
            byte_out   <= '0;
            byte_rs    <= 1'b0;
            mode4      <= 1'b0;
            phase      <= 1'b0;
            hi         <= '0;
            hi_rs      <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (strobe) begin
                if (!mode4) begin
                    byte_valid <= 1'b1;
                    byte_out   <= {port[7:4], 4'h0};
                    byte_rs    <= port[0];
                    if (!port[0] && port[7:4] == 4'h2) mode4 <= 1'b1;
                end else if (!phase) begin
                    hi    <= port[7:4];
                    hi_rs <= port[0];
                    phase <= 1'b1;
                end else begin
                    byte_valid <= 1'b1;
                    byte_out   <= {hi, port[7:4]};
                    byte_rs    <= hi_rs;
                    phase      <= 1'b0;
                end
            end
        end
    end

`ifdef LCD_RX_DDRAM_EN
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic [BW-1:0] mem [DEPTH];
    logic [6:0]    cursor;
    logic          clearing, pend_v, pend_rs;
    logic [AW-1:0] clr_idx;
    logic [BW-1:0] pend_b;
    logic          ap_v, ap_rs;
    logic [BW-1:0] ap_b;

    // A held byte is replayed once the refill finishes
    always_comb begin
        ap_v  = 1'b0;
        ap_b  = byte_out;
        ap_rs = byte_rs;
        if (!clearing) begin
            ap_v  = pend_v | byte_valid;
            ap_b  = pend_v ? pend_b : byte_out;
            ap_rs = pend_v ? pend_rs : byte_rs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h20;
            cursor   <= '0;
            clearing <= 1'b0;
            clr_idx  <= '0;
            pend_v   <= 1'b0;
            pend_b   <= '0;
            pend_rs  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            if (clearing) begin
                mem[clr_idx] <= 8'h20;
                clr_idx      <= clr_idx + AW'(1);
                if (clr_idx == AW'(DEPTH - 1)) begin
                    clearing <= 1'b0;
                    cursor   <= '0;
                end
                if (byte_valid) begin
                    pend_v  <= 1'b1;
                    pend_b  <= byte_out;
                    pend_rs <= byte_rs;
                end
            end else if (pend_v) begin
                pend_v  <= byte_valid;
                pend_b  <= byte_out;
                pend_rs <= byte_rs;
            end
            if (ap_v) begin
                if (!ap_rs) begin
                    if (ap_b == 8'h01) begin
                        clearing <= 1'b1;
                        clr_idx  <= '0;
                    end else if (ap_b[7]) begin
                        cursor <= ap_b[6:0];
                    end
                end else begin
                    if (cursor[6:4] == 3'd0)      mem[{1'b0, cursor[3:0]}] <= ap_b;
                    else if (cursor[6:4] == 3'd4) mem[{1'b1, cursor[3:0]}] <= ap_b;
                    cursor[3:0] <= cursor[3:0] + 4'(1);
                end
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_lcd_i2c_rx.sv
// Directed bench for lcd_i2c_rx: bit-banged I2C writes with hand-computed decode results.
module tb_lcd_i2c_rx;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [4:0] rd_addr = '0;
    wire        sda;
    logic [7:0] port, byte_out, rd_data;
    logic       byte_valid, byte_rs, mode4, busy;

    int         checks = 0;
    int         failures = 0;
    int         vcount = 0;
    logic [7:0] last_b = '0;
    logic       last_rs = 1'b0;
    logic       a;

    lcd_i2c_rx dut (
        .clk(clk), .rst(rst), .sda(sda), .sclk(scl),
        .port(port), .byte_valid(byte_valid), .byte_out(byte_out),
        .byte_rs(byte_rs), .mode4(mode4), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;
    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        if (byte_valid) begin
            vcount  <= vcount + 1;
            last_b  <= byte_out;
            last_rs <= byte_rs;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; scl = 1'b1; wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        m_low = 1'b0; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; wait_clk(Q);
        scl = 1'b1; wait_clk(2 * Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic clock_ack(output logic ack);
        m_low = 1'b0; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        ack = sda; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        clock_ack(ack);
    endtask

    task automatic wr(input logic [7:0] b);
        logic ack;
        send_byte(b, ack);
        check("data_ack", 32'(ack), 32'd0);
    endtask

    task automatic lcd_byte(input logic [7:0] b, input logic rs);
        wr({b[7:4], 3'b110, rs});
        wr({b[7:4], 3'b100, rs});
        wr({b[3:0], 3'b110, rs});
        wr({b[3:0], 3'b100, rs});
    endtask

    task automatic open_tx();
        logic ack;
        i2c_start();
        send_byte(8'h4E, ack);
        check("addr_ack", 32'(ack), 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] ad, input logic [7:0] exp);
        rd_addr = ad;
        wait_clk(2);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        check("rst_port", 32'(port), 32'hFF);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_byte", 32'(byte_out), 32'd0);
        check("rst_rs", 32'(byte_rs), 32'd0);
        check("rst_mode4", 32'(mode4), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);

        // Foreign address: no ACK, no busy, port untouched
        i2c_start();
        send_byte(8'h50, a);
        check("nack_0x50", 32'(a), 32'd1);
        check("busy_foreign", 32'(busy), 32'd0);
        i2c_stop();
        check("port_foreign", 32'(port), 32'hFF);

        // 8-bit mode byte, busy window
        open_tx();
        check("busy_on", 32'(busy), 32'd1);
        wr(8'h3C);
        wr(8'h38);
        i2c_stop();
        wait_clk(6);
        check("busy_off", 32'(busy), 32'd0);
        check("port_38", 32'(port), 32'h38);
        check("cnt_8bit", 32'(vcount), 32'd1);
        check("byte_8bit", 32'(last_b), 32'h30);
        check("rs_8bit", 32'(last_rs), 32'd0);
        check("mode4_still0", 32'(mode4), 32'd0);

        // Function set 0x2x switches to 4-bit mode
        open_tx();
        wr(8'h2C);
        wr(8'h28);
        i2c_stop();
        check("mode4_set", 32'(mode4), 32'd1);
        check("byte_0x20", 32'(last_b), 32'h20);

        // 4-bit command then data (cursor 0x40, then 'A')
        open_tx();
        lcd_byte(8'h80, 1'b0);
        i2c_stop();
        check("cnt_cmd80", 32'(vcount), 32'd3);
        check("byte_cmd80", 32'(last_b), 32'h80);
        check("rs_cmd80", 32'(last_rs), 32'd0);
        open_tx();
        lcd_byte(8'hC0, 1'b0);
        lcd_byte(8'h41, 1'b1);
        i2c_stop();
        check("cnt_data41", 32'(vcount), 32'd5);
        check("byte_data41", 32'(last_b), 32'h41);
        check("rs_data41", 32'(last_rs), 32'd1);

`ifdef LCD_RX_DDRAM_EN
        rd_check("ddram_row1", 5'd16, 8'h41);
        rd_check("ddram_blank", 5'd0, 8'h20);
        open_tx();
        lcd_byte(8'h8F, 1'b0);
        for (int i = 0; i < 16; i++) lcd_byte(8'(8'h30 + i), 1'b1);
        i2c_stop();
        rd_check("wrap_idx15", 5'd15, 8'h30);
        rd_check("wrap_idx0", 5'd0, 8'h31);
        rd_check("wrap_idx14", 5'd14, 8'h3F);
        open_tx();
        lcd_byte(8'h01, 1'b0);
        i2c_stop();
        wait_clk(40);
        rd_check("clr_idx0", 5'd0, 8'h20);
        rd_check("clr_idx15", 5'd15, 8'h20);
        rd_check("clr_idx16", 5'd16, 8'h20);
`else
        rd_check("rd_tied", 5'd16, 8'h00);
`endif

        // Reset after bit 5 of a data byte
        open_tx();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("midrst_sda", 32'(sda), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_port", 32'(port), 32'hFF);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        clock_ack(a);
        check("midrst_noack", 32'(a), 32'd1);
        i2c_stop();
        check("midrst_cnt", 32'(vcount), 32'd5);
        check("midrst_mode4", 32'(mode4), 32'd0);
        open_tx();
        wr(8'h3C);
        wr(8'h38);
        i2c_stop();
        check("post_rst_cnt", 32'(vcount), 32'd6);
        check("post_rst_byte", 32'(last_b), 32'h30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
